pong_match_seq: RTL and testbench
=================================

PONG_MATCH_SEQ -- requirements
Module: pong_match_seq

Interface
REQ-001 The module SHALL have parameter c_GAME_WIDTH, default 40, meaning the playfield width in board units.
REQ-002 The module SHALL have parameter c_GAME_HEIGHT, default 30, meaning the playfield height in board units.
REQ-003 The module SHALL have parameter c_PADDLE_HEIGHT, default 6, meaning the paddle length in board units.
REQ-004 The module SHALL have parameter c_SCORE_LIMIT, default 9, meaning the points needed to win, range 1..15.
REQ-005 The module SHALL have parameter c_SERVE_DELAY, default 25000000, meaning the inactive clock cycles between a point and the next serve, minimum 2.
REQ-006 i_Clk  input  1  system clock; every register SHALL update on its rising edge.
REQ-007 i_Rst  input  1  reset, synchronous and active-high.
REQ-008 i_Start  input  1  start/restart request, level-sampled each cycle.
REQ-009 i_Ball_X  input  6  current ball column from the ball controller.
REQ-010 i_Ball_Y  input  6  current ball row from the ball controller.
REQ-011 i_Paddle_Y_P1  input  6  top row of the left paddle (column 0).
REQ-012 i_Paddle_Y_P2  input  6  top row of the right paddle (column c_GAME_WIDTH-1).
REQ-013 o_Game_Active  output  1  ball-run enable to the ball controller.
REQ-014 o_P1_Score / o_P2_Score  output  4 each  current points.
REQ-015 o_Point_P1 / o_Point_P2  output  1 each  one-cycle pulse on the cycle the score increments.
REQ-016 o_Winner  output  2  winner indicator: 00 none, 01 P1, 10 P2.
REQ-017 o_State  output  3  current state encoding: IDLE=0, RUNNING=1, SCORE=2, SERVE_WAIT=3, GAME_OVER=4.

Function
REQ-018 The block SHALL implement a registered FSM with states IDLE, RUNNING, SCORE, SERVE_WAIT and GAME_OVER.
REQ-019 In IDLE, i_Start=1 SHALL transition the FSM to RUNNING on the next edge.
REQ-020 o_Game_Active SHALL be 1 only while o_State==RUNNING, with the output registered and aligned to the state.
REQ-021 Paddle hit test: row r SHALL count as covered by a paddle when Paddle_Y <= r and r <= Paddle_Y+c_PADDLE_HEIGHT-1, with the sum computed at 7 bits so no wrap occurs.
REQ-022 P2-point condition: in RUNNING, i_Ball_X==0 with i_Ball_Y not covered by the P1 paddle.
REQ-023 P1-point condition: in RUNNING, i_Ball_X==c_GAME_WIDTH-1 with i_Ball_Y not covered by the P2 paddle.
REQ-024 A point condition true in cycle N SHALL put the FSM in SCORE at N+1, with o_Game_Active=0 from N+1.
REQ-025 In SCORE (one cycle), the scoring player's count SHALL increment by 1 and the matching o_Point_* SHALL pulse high for exactly that cycle.
REQ-026 From SCORE, if the new score equals c_SCORE_LIMIT the FSM SHALL go to GAME_OVER and set o_Winner; otherwise it SHALL go to SERVE_WAIT.
REQ-027 On SERVE_WAIT entry, the serve counter SHALL clear to 0 and then increment each cycle.
REQ-028 When the serve counter reaches c_SERVE_DELAY-1, the FSM SHALL go to RUNNING, so SERVE_WAIT lasts exactly c_SERVE_DELAY cycles.
REQ-029 At most one point SHALL be awarded per RUNNING episode; point conditions outside RUNNING SHALL be ignored.
REQ-030 If both point conditions are true in the same cycle (only possible when c_GAME_WIDTH==1), P1 SHALL take priority.
REQ-031 i_Start SHALL be ignored in RUNNING, SCORE and SERVE_WAIT.
REQ-032 In GAME_OVER, o_Winner and the scores SHALL hold.
REQ-033 In GAME_OVER, i_Start=1 SHALL clear both scores and o_Winner to 0 and go to SERVE_WAIT.
REQ-034 Scores SHALL never exceed c_SCORE_LIMIT and SHALL never wrap.

Reset
REQ-035 i_Rst=1 at any edge, including mid-SERVE_WAIT or mid-SCORE, SHALL force State=IDLE and o_Game_Active=0.
REQ-036 The same reset SHALL force both scores, both o_Point_* outputs, o_Winner and the serve counter to 0.
REQ-037 Reset SHALL take priority over i_Start and over any point condition in the same cycle.
REQ-038 After i_Rst deasserts, the FSM SHALL remain in IDLE until i_Start=1.

Verification (c_SCORE_LIMIT=3, c_SERVE_DELAY=4, default geometry)
REQ-039 Reset then i_Start=1 for one cycle -> o_State=1 and o_Game_Active=1 one cycle later; scores 0/0.
REQ-040 RUNNING, Ball_X=0, Ball_Y=20, Paddle_Y_P1=5 -> next cycle State=2, o_Point_P2=1, P2_Score=1; then 4 cycles in State=3; then State=1.
REQ-041 RUNNING, Ball_X=0, Ball_Y=10, Paddle_Y_P1=5 (covered rows 5..10), held 20 cycles -> no point; State stays 1.
REQ-042 Paddle_Y_P2=60, Ball_X=39, Ball_Y=1 -> 7-bit check gives rows 60..65 with no wrap to 0..1 -> P1 point awarded.
REQ-043 Three P1 misses -> P1 gets 3, State=4, o_Winner=01, o_Game_Active=0; i_Start then clears scores/Winner and gives State=3, then 1 after 4 cycles.
REQ-044 i_Rst=1 during the second cycle of SERVE_WAIT with P2_Score=2 -> next cycle State=0, scores 0/0, o_Winner=00, Game_Active=0.

Source files
------------

// File: rtl/pong_match_seq_if.sv
// Signal bundle between the pong match sequencer and its ball/paddle/score neighbours.
// The master side drives the game inputs; the slave side is the sequencer.
interface pong_match_seq_if;
    logic       i_Start;
    logic [5:0] i_Ball_X;
    logic [5:0] i_Ball_Y;
    logic [5:0] i_Paddle_Y_P1;
    logic [5:0] i_Paddle_Y_P2;
    logic       o_Game_Active;
    logic [3:0] o_P1_Score;
    logic [3:0] o_P2_Score;
    logic       o_Point_P1;
    logic       o_Point_P2;
    logic [1:0] o_Winner;
    logic [2:0] o_State;

    modport master (
        output i_Start, i_Ball_X, i_Ball_Y, i_Paddle_Y_P1, i_Paddle_Y_P2,
        input  o_Game_Active, o_P1_Score, o_P2_Score, o_Point_P1, o_Point_P2,
        input  o_Winner, o_State
    );

    modport slave (
        input  i_Start, i_Ball_X, i_Ball_Y, i_Paddle_Y_P1, i_Paddle_Y_P2,
        output o_Game_Active, o_P1_Score, o_P2_Score, o_Point_P1, o_Point_P2,
        output o_Winner, o_State
    );
endinterface

// File: rtl/pong_match_seq.sv
// Pong match sequencer: detects missed balls, keeps score, paces serves and
// declares the winner once a player reaches the score limit.
module pong_match_seq #(
    parameter int unsigned c_GAME_WIDTH    = 40,
    parameter int unsigned c_GAME_HEIGHT   = 30,
    parameter int unsigned c_PADDLE_HEIGHT = 6,
    parameter int unsigned c_SCORE_LIMIT   = 9,
    parameter int unsigned c_SERVE_DELAY   = 25000000
) (
    input  logic            i_Clk,
    input  logic            i_Rst,
    pong_match_seq_if.slave bus
);

    localparam int unsigned c_CNT_W = $clog2(c_SERVE_DELAY);

    localparam logic [5:0]         c_RIGHT_COL  = 6'(c_GAME_WIDTH - 1);
    localparam logic [6:0]         c_PAD_SPAN   = 7'(c_PADDLE_HEIGHT - 1);
    localparam logic [3:0]         c_LIMIT      = 4'(c_SCORE_LIMIT);
    localparam logic [c_CNT_W-1:0] c_SERVE_LAST = c_CNT_W'(c_SERVE_DELAY - 1);

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StRunning   = 3'd1,
        StScore     = 3'd2,
        StServeWait = 3'd3,
        StGameOver  = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [3:0]         p1_score_q, p2_score_q;
    logic               point_p1_q, point_p2_q;
    logic               point_p1_d, point_p2_d;
    logic [1:0]         winner_q;
    logic               game_active_q;
    logic [c_CNT_W-1:0] serve_cnt_q;

    logic p1_covered, p2_covered;
    logic p1_point, p2_point;
    logic [3:0] scorer_score;

    // 7-bit compare so a paddle near row 63 cannot wrap onto the top rows.
    assign p1_covered = ({1'b0, bus.i_Paddle_Y_P1} <= {1'b0, bus.i_Ball_Y}) &&
                        ({1'b0, bus.i_Ball_Y} <= {1'b0, bus.i_Paddle_Y_P1} + c_PAD_SPAN);
    assign p2_covered = ({1'b0, bus.i_Paddle_Y_P2} <= {1'b0, bus.i_Ball_Y}) &&
                        ({1'b0, bus.i_Ball_Y} <= {1'b0, bus.i_Paddle_Y_P2} + c_PAD_SPAN);

    assign p1_point     = (bus.i_Ball_X == c_RIGHT_COL) && !p2_covered;
    assign p2_point     = (bus.i_Ball_X == 6'd0) && !p1_covered;
    assign scorer_score = point_p1_q ? p1_score_q : p2_score_q;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        point_p1_d = 1'b0;
        point_p2_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.i_Start) state_d = StRunning;
            end
            StRunning: begin
                // P1 wins ties (only reachable with a one-column field).
                if (p1_point) begin
                    state_d    = StScore;
                    point_p1_d = 1'b1;
                end else if (p2_point) begin
                    state_d    = StScore;
                    point_p2_d = 1'b1;
                end
            end
            StScore: begin
                state_d = (scorer_score == c_LIMIT) ? StGameOver : StServeWait;
            end
            StServeWait: begin
                if (serve_cnt_q == c_SERVE_LAST) state_d = StRunning;
            end
            StGameOver: begin
                if (bus.i_Start) state_d = StServeWait;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            p1_score_q    <= '0;
            p2_score_q    <= '0;
            point_p1_q    <= 1'b0;
            point_p2_q    <= 1'b0;
            winner_q      <= 2'b00;
            game_active_q <= 1'b0;
            serve_cnt_q   <= '0;
        end else begin
            point_p1_q    <= point_p1_d;
            point_p2_q    <= point_p2_d;
            game_active_q <= (state_d == StRunning);

            if (point_p1_d && (p1_score_q != c_LIMIT)) p1_score_q <= p1_score_q + 4'd1;
            if (point_p2_d && (p2_score_q != c_LIMIT)) p2_score_q <= p2_score_q + 4'd1;

            if ((state_q == StScore) && (state_d == StGameOver)) begin
                winner_q <= point_p1_q ? 2'b01 : 2'b10;
            end

            if ((state_q == StGameOver) && (state_d == StServeWait)) begin
                p1_score_q <= '0;
                p2_score_q <= '0;
                winner_q   <= 2'b00;
            end

            // Held at zero outside SERVE_WAIT so every entry starts counting from 0.
            if (state_q == StServeWait) begin
                serve_cnt_q <= serve_cnt_q + 1'b1;
            end else begin
                serve_cnt_q <= '0;
            end
        end
    end

    always_comb begin
        bus.o_State       = state_q;
        bus.o_Game_Active = game_active_q;
        bus.o_P1_Score    = p1_score_q;
        bus.o_P2_Score    = p2_score_q;
        bus.o_Point_P1    = point_p1_q;
        bus.o_Point_P2    = point_p2_q;
        bus.o_Winner      = winner_q;
    end

endmodule

// File: tb/tb_pong_match_seq.sv
// Bench for pong_match_seq: directed match scenarios followed by random play,
// every output compared each cycle against a rule-level game model.
module tb_pong_match_seq;

    localparam int W     = 40;
    localparam int H     = 30;
    localparam int PH    = 6;
    localparam int LIMIT = 3;
    localparam int DELAY = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    // Reference game state
    int m_state = 0;
    int m_p1 = 0, m_p2 = 0, m_win = 0, m_left = 0, m_last = 0;
    int m_pt1 = 0, m_pt2 = 0;

    pong_match_seq_if bus ();

    pong_match_seq #(
        .c_GAME_WIDTH   (W),
        .c_GAME_HEIGHT  (H),
        .c_PADDLE_HEIGHT(PH),
        .c_SCORE_LIMIT  (LIMIT),
        .c_SERVE_DELAY  (DELAY)
    ) dut (
        .i_Clk(clk),
        .i_Rst(rst),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic bit covered(input int py, input int by);
        return (py <= by) && (by <= py + PH - 1);
    endfunction

    task automatic model_step(input bit r, input bit st, input int bx, input int by,
                              input int py1, input int py2);
        bit p1_pt, p2_pt;
        m_pt1 = 0;
        m_pt2 = 0;
        if (r) begin
            m_state = 0; m_p1 = 0; m_p2 = 0; m_win = 0; m_left = 0;
        end else begin
            case (m_state)
                0: if (st) m_state = 1;
                1: begin
                    p1_pt = (bx == W - 1) && !covered(py2, by);
                    p2_pt = (bx == 0) && !covered(py1, by);
                    if (p1_pt) begin
                        m_p1++; m_pt1 = 1; m_last = 1; m_state = 2;
                    end else if (p2_pt) begin
                        m_p2++; m_pt2 = 1; m_last = 2; m_state = 2;
                    end
                end
                2: begin
                    if (((m_last == 1) ? m_p1 : m_p2) == LIMIT) begin
                        m_state = 4; m_win = m_last;
                    end else begin
                        m_state = 3; m_left = DELAY;
                    end
                end
                3: begin
                    m_left--;
                    if (m_left == 0) m_state = 1;
                end
                4: if (st) begin
                    m_p1 = 0; m_p2 = 0; m_win = 0; m_state = 3; m_left = DELAY;
                end
                default: m_state = 0;
            endcase
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input bit r, input bit st, input int bx, input int by,
                        input int py1, input int py2);
        rst               = r;
        bus.i_Start       = st;
        bus.i_Ball_X      = 6'(bx);
        bus.i_Ball_Y      = 6'(by);
        bus.i_Paddle_Y_P1 = 6'(py1);
        bus.i_Paddle_Y_P2 = 6'(py2);
        @(posedge clk);
        model_step(r, st, bx, by, py1, py2);
        #1;
        chk("state",    32'(bus.o_State),       32'(m_state));
        chk("active",   32'(bus.o_Game_Active), 32'(m_state == 1));
        chk("p1_score", 32'(bus.o_P1_Score),    32'(m_p1));
        chk("p2_score", 32'(bus.o_P2_Score),    32'(m_p2));
        chk("point_p1", 32'(bus.o_Point_P1),    32'(m_pt1));
        chk("point_p2", 32'(bus.o_Point_P2),    32'(m_pt2));
        chk("winner",   32'(bus.o_Winner),      32'(m_win));
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 20, 15, 5, 5);
    endtask

    initial begin
        // Reset, then IDLE must ignore everything but i_Start
        tick(1, 1, 0, 20, 5, 5);
        tick(1, 0, 20, 15, 5, 5);
        tick(0, 0, 0, 20, 5, 5);
        idle_ticks(2);
        tick(0, 1, 20, 15, 5, 5);
        // P2 point: P1 paddle misses row 20
        tick(0, 0, 0, 20, 5, 5);
        idle_ticks(6);
        // Ball on the bottom row of the P1 paddle: no point
        for (int i = 0; i < 20; i++) tick(0, 1, 0, 10, 5, 5);
        // P2 paddle at 60 covers 60..65 only, row 1 is a miss
        tick(0, 0, 39, 1, 5, 60);
        idle_ticks(6);
        // Two more P1 points end the match
        tick(0, 0, 39, 20, 5, 5);
        idle_ticks(6);
        tick(0, 0, 39, 20, 5, 5);
        // Point conditions in GAME_OVER are ignored
        tick(0, 0, 39, 20, 5, 5);
        tick(0, 0, 0, 20, 5, 5);
        tick(0, 1, 20, 15, 5, 5);
        idle_ticks(6);
        // Two P2 points, then reset during the second SERVE_WAIT cycle
        tick(0, 0, 0, 20, 5, 5);
        idle_ticks(6);
        tick(0, 0, 0, 20, 5, 5);
        idle_ticks(2);
        tick(1, 1, 0, 20, 5, 5);
        idle_ticks(3);
        tick(0, 1, 0, 20, 5, 5);
        tick(0, 0, 0, 20, 5, 5);

        for (int i = 0; i < 4000; i++) begin
            int sel, bx;
            sel = int'($urandom_range(0, 7));
            bx  = (sel == 0) ? 0 : (sel == 1) ? W - 1 : int'($urandom_range(0, 63));
            tick($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0, bx,
                 int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                 int'($urandom_range(0, 63)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
